// File: rtl/sm_adder_operand_sequencer.sv
`timescale 1ns/1ps
// Purpose: buffer sign-magnitude operand pairs, issue them to a ROM adder, return sums in order.
// Latency: accept at edge 0, issue at edge 1, sum visible on out_sum after edge 2+ROM_LATENCY.
// Backpressure: issue is credit-limited by output buffer space; in_ready is registered !full.
module sm_adder_operand_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROM_LATENCY = 1,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  input  logic [DATA_WIDTH:0]   add_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_sum,
  output logic                  busy
);

  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = FAW + 1;
  localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  // Wide enough for in_flight + buffered results without overflow.
  localparam int CRW = $clog2(OUT_DEPTH + ROM_LATENCY + 2) + 1;

  localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);
  localparam logic [CRW-1:0] OUT_LIMIT = CRW'(OUT_DEPTH);
  localparam logic [OAW-1:0] OUT_LAST  = OAW'(OUT_DEPTH - 1);

  // Input FIFO state
  logic [DATA_WIDTH-1:0] fa_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fb_mem [FIFO_DEPTH];
  logic [FAW-1:0]        fwr_q, frd_q;
  logic [FCW-1:0]        fcnt_q, fcnt_d;
  logic                  in_ready_q;
  logic                  push, issue;

  // Issue registers and latency tags
  logic [DATA_WIDTH-1:0] add_a_q, add_b_q;
  logic [ROM_LATENCY:0]  tag_q, tag_d;
  logic [CRW-1:0]        in_flight;
  logic                  credit_ok;

  // Output buffer state
  logic [DATA_WIDTH:0]   omem [OUT_DEPTH];
  logic [OAW-1:0]        owr_q, ord_q;
  logic [CRW-1:0]        ocnt_q, ocnt_d;
  logic                  capture, out_pop;
  logic [DATA_WIDTH:0]   sum_norm;

  assign push    = in_valid && in_ready_q;
  assign out_pop = out_valid && out_ready;
  // The oldest tag stage marks the cycle whose add_sum belongs to an issued pair.
  assign capture = tag_q[ROM_LATENCY];

  // Count of issued pairs whose sums have not yet reached the output buffer.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= ROM_LATENCY; i++) begin
      in_flight = in_flight + CRW'(tag_q[i]);
    end
  end

  // A slot is reserved at issue time, so a pop this cycle frees one for an issue this cycle.
  assign credit_ok = (in_flight + ocnt_q - CRW'(out_pop)) < OUT_LIMIT;
  assign issue     = (fcnt_q != '0) && credit_ok;

  // Next-state counts and tag shift; negative zero collapses to plain zero at capture.
  always_comb begin
    fcnt_d   = fcnt_q + FCW'(push) - FCW'(issue);
    ocnt_d   = ocnt_q + CRW'(capture) - CRW'(out_pop);
    tag_d    = {tag_q[ROM_LATENCY-1:0], issue};
    sum_norm = (add_sum[DATA_WIDTH-1:0] == '0) ? '0 : add_sum;
  end

  // Control state: pointers, counts, tags and the adder operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwr_q      <= '0;
      frd_q      <= '0;
      fcnt_q     <= '0;
      in_ready_q <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      tag_q      <= '0;
      owr_q      <= '0;
      ord_q      <= '0;
      ocnt_q     <= '0;
    end else begin
      fcnt_q     <= fcnt_d;
      in_ready_q <= (fcnt_d != FIFO_FULL);
      tag_q      <= tag_d;
      ocnt_q     <= ocnt_d;
      if (push) begin
        fwr_q <= fwr_q + FAW'(1);
      end
      if (issue) begin
        frd_q   <= frd_q + FAW'(1);
        add_a_q <= fa_mem[frd_q];
        add_b_q <= fb_mem[frd_q];
      end
      if (capture) begin
        owr_q <= (owr_q == OUT_LAST) ? '0 : owr_q + OAW'(1);
      end
      if (out_pop) begin
        ord_q <= (ord_q == OUT_LAST) ? '0 : ord_q + OAW'(1);
      end
    end
  end

  // Storage arrays need no reset; validity is tracked by the counts above.
  always_ff @(posedge clk) begin
    if (push) begin
      fa_mem[fwr_q] <= in_a;
      fb_mem[fwr_q] <= in_b;
    end
    if (capture) begin
      omem[owr_q] <= sum_norm;
    end
  end

  assign in_ready  = in_ready_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_valid = (ocnt_q != '0);
  assign out_sum   = out_valid ? omem[ord_q] : '0;
  assign busy      = (fcnt_q != '0) || (tag_q != '0) || out_valid;

endmodule

// File: tb/tb_sm_adder_operand_sequencer.sv
`timescale 1ns/1ps
// Bench for sm_adder_operand_sequencer with a one-cycle ROM adder model.
// Expected sums come from signed integer arithmetic on the accepted operands.
// A negedge monitor records accepted operands and returned sums as queues.
module tb_sm_adder_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] in_a, in_b, add_a, add_b;
  logic [8:0] add_sum, out_sum;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  always #5 clk = ~clk;

  sm_adder_operand_sequencer #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .ROM_LATENCY(1), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  // ROM adder behaviour: equal magnitudes with differing signs keep a's sign (may give -0).
  function automatic logic [8:0] rom_add(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ma, mb;
    ma = {1'b0, a[6:0]};
    mb = {1'b0, b[6:0]};
    if (a[7] == b[7])  return {a[7], ma + mb};
    else if (ma >= mb) return {a[7], ma - mb};
    else               return {b[7], mb - ma};
  endfunction

  // Reference: true signed sum re-encoded as sign-magnitude, zero always positive.
  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
    int va, vb, v;
    va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
    vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    v  = va + vb;
    if (v < 0) return {1'b1, 8'(-v)};
    else       return {1'b0, 8'(v)};
  endfunction

  always @(posedge clk) add_sum <= rom_add(add_a, add_b);

  // Handshakes seen here complete at the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)   exp_q.push_back(ref_sum(in_a, in_b));
      if (out_valid && out_ready) got_q.push_back(out_sum);
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (add_a !== 8'h00)    begin failures++; $display("FAIL reset_add_a got=%h exp=00", add_a); end
    checks++; if (add_b !== 8'h00)    begin failures++; $display("FAIL reset_add_b got=%h exp=00", add_b); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_sum !== 9'h000) begin failures++; $display("FAIL reset_out_sum got=%h exp=000", out_sum); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        checks++; if (add_a !== 8'h01) begin failures++; $display("FAIL single_add_a got=%h exp=01", add_a); end
        checks++; if (add_b !== 8'h02) begin failures++; $display("FAIL single_add_b got=%h exp=02", add_b); end
      end
      checks++;
      if (out_valid !== (i == 3)) begin
        failures++; $display("FAIL single_out_valid cycle=%0d got=%0b exp=%0b", i, out_valid, (i == 3));
      end
    end
    checks++; if (out_sum !== 9'h003) begin failures++; $display("FAIL single_out_sum got=%h exp=003", out_sum); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL single_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta[4];
    logic [7:0] tb[4];
    logic [8:0] te[4];
    ta[0] = 8'h02; tb[0] = 8'h84; te[0] = 9'h102;
    ta[1] = 8'h82; tb[1] = 8'h82; te[1] = 9'h104;
    ta[2] = 8'hB9; tb[2] = 8'h79; te[2] = 9'h040;
    ta[3] = 8'hFF; tb[3] = 8'hFF; te[3] = 9'h1FE;
    out_ready = 1'b1;
    for (int s = 0; s < 12; s++) begin
      checks++;
      if (out_valid !== (s >= 4 && s <= 7)) begin
        failures++; $display("FAIL b2b_out_valid step=%0d got=%0b exp=%0b", s, out_valid, (s >= 4 && s <= 7));
      end
      if (s >= 4 && s <= 7) begin
        checks++;
        if (out_sum !== te[s-4]) begin
          failures++; $display("FAIL b2b_out_sum idx=%0d got=%h exp=%h", s - 4, out_sum, te[s-4]);
        end
      end
      if (s < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready step=%0d got=%0b exp=1", s, in_ready); end
        in_valid = 1'b1; in_a = ta[s]; in_b = tb[s];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_neg_zero();
    logic [7:0] ta[3];
    logic [7:0] tb[3];
    logic [8:0] te[3];
    int cyc;
    ta[0] = 8'h85; tb[0] = 8'h05; te[0] = 9'h000;
    ta[1] = 8'h80; tb[1] = 8'h00; te[1] = 9'h000;
    ta[2] = 8'h81; tb[2] = 8'h00; te[2] = 9'h101;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = ta[i]; in_b = tb[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cyc = 0;
    while (got_q.size() < 3 && cyc < 30) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (got_q.size() != 3) begin
      failures++; $display("FAIL negzero_count got=%0d exp=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== te[i]) begin failures++; $display("FAIL negzero_sum idx=%0d got=%h exp=%h", i, got_q[i], te[i]); end
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (exp_q.size() < 10); in_a = 8'($urandom); in_b = 8'($urandom);
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 8) begin failures++; $display("FAIL stall_accepted got=%0d exp=8", exp_q.size()); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid got=%0b exp=1", out_valid); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL stall_no_output got=%0d exp=0", got_q.size()); end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL stall_returned got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_busy_end got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%0b exp=1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    checks++; if (add_a !== 8'h00)    begin failures++; $display("FAIL rstmid_add_a got=%h exp=00", add_a); end
    checks++; if (add_b !== 8'h00)    begin failures++; $display("FAIL rstmid_add_b got=%h exp=00", add_b); end
    checks++; if (out_sum !== 9'h000) begin failures++; $display("FAIL rstmid_out_sum got=%h exp=000", out_sum); end
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL rstmid_outputs got=%0d exp=1", got_q.size());
    end else begin
      checks++; if (got_q[0] !== 9'h002) begin failures++; $display("FAIL rstmid_sum got=%h exp=002", got_q[0]); end
    end
  endtask

  task automatic test_random();
    int cyc, max_out, outst;
    exp_q.delete(); got_q.delete();
    cyc = 0; max_out = 0;
    while (exp_q.size() < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1; cyc++;
      outst = exp_q.size() - got_q.size();
      if (outst > max_out) max_out = outst;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 1000) begin failures++; $display("FAIL random_accepted got=%0d exp=1000", exp_q.size()); end
    checks++; if (max_out > 8) begin failures++; $display("FAIL random_outstanding got=%0d exp<=8", max_out); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL random_busy_end got=%0b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_neg_zero();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
